// File: rtl/lc3_int_arbiter_if.sv
// Request/acknowledge bus between the interrupt arbiter and the LC-3 control FSM.
// The arbiter drives the granted vector/priority/source; the FSM supplies PSR priority and ack.
interface lc3_int_arbiter_if #(
  parameter int PRI_W = 3,
  parameter int VEC_W = 8,
  parameter int IDX_W = 2
);
  logic [PRI_W-1:0] cur_pl;
  logic             int_req;
  logic             int_ack;
  logic [VEC_W-1:0] int_vec;
  logic [PRI_W-1:0] int_pri;
  logic [IDX_W-1:0] int_src;

  modport master (
    input  cur_pl,
    input  int_ack,
    output int_req,
    output int_vec,
    output int_pri,
    output int_src
  );

  modport slave (
    output cur_pl,
    output int_ack,
    input  int_req,
    input  int_vec,
    input  int_pri,
    input  int_src
  );
endinterface

// File: rtl/lc3_int_arbiter.sv
// Interrupt arbiter for the LC-3 INT sequence: per-source pending/config state,
// priority selection against PSR priority, and a req/ack handshake to the control FSM.
//
// state | meaning
// IDLE  | no request outstanding; latch the winner when one is eligible
// REQ   | int_req high, granted vec/pri/src frozen until int_ack
// HOLD  | one-cycle gap after ack before arbitration resumes
module lc3_int_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int PRI_W     = 3,
  parameter int VEC_W     = 8,
  parameter int EDGE_MODE = 1,
  localparam int IDX_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [PRI_W-1:0]   cfg_pri,
  input  logic [VEC_W-1:0]   cfg_vec,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] ovf,
  lc3_int_arbiter_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [PRI_W-1:0]   pri_q [NUM_SRC];
  logic [PRI_W-1:0]   pri_d [NUM_SRC];
  logic [VEC_W-1:0]   vec_q [NUM_SRC];
  logic [VEC_W-1:0]   vec_d [NUM_SRC];
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] ovf_q, ovf_d;
  logic [NUM_SRC-1:0] prev_irq_q, prev_irq_d;
  logic [VEC_W-1:0]   int_vec_q, int_vec_d;
  logic [PRI_W-1:0]   int_pri_q, int_pri_d;
  logic [IDX_W-1:0]   int_src_q, int_src_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] cfg_hit;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [PRI_W-1:0]   win_pri;
  logic [VEC_W-1:0]   win_vec;

  // Config file and pending/overflow tracking.
  always_comb begin
    rise       = src_irq & ~prev_irq_q;
    prev_irq_d = src_irq;
    clr        = '0;
    cfg_hit    = '0;
    en_d       = en_q;
    pri_d      = pri_q;
    vec_d      = vec_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state_q == S_REQ && bus.int_ack && int_src_q == IDX_W'(i)) begin
        clr[i] = 1'b1;
      end
      if (cfg_we && cfg_idx == IDX_W'(i)) begin
        cfg_hit[i] = 1'b1;
        en_d[i]    = cfg_en;
        pri_d[i]   = cfg_pri;
        vec_d[i]   = cfg_vec;
      end
    end
    if (EDGE_MODE != 0) begin
      // A new edge beats a same-cycle ack clear; only an unabsorbed edge counts as lost.
      pending_d = (pending_q & ~clr) | rise;
      ovf_d     = (ovf_q | (rise & pending_q & ~clr)) & ~cfg_hit;
    end else begin
      pending_d = src_irq;
      ovf_d     = '0;
    end
  end

  // Strict '>' on the running best keeps the lowest index on a priority tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pri   = '0;
    win_vec   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_q[i] && en_q[i] && (pri_q[i] > bus.cur_pl) &&
          (!win_found || pri_q[i] > win_pri)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_pri   = pri_q[i];
        win_vec   = vec_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    int_vec_d = int_vec_q;
    int_pri_d = int_pri_q;
    int_src_d = int_src_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d   = S_REQ;
          int_vec_d = win_vec;
          int_pri_d = win_pri;
          int_src_d = win_idx;
        end
      end
      S_REQ: begin
        if (bus.int_ack) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      en_q       <= '0;
      pending_q  <= '0;
      ovf_q      <= '0;
      prev_irq_q <= '0;
      int_vec_q  <= '0;
      int_pri_q  <= '0;
      int_src_q  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        pri_q[i] <= '0;
        vec_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      prev_irq_q <= prev_irq_d;
      int_vec_q  <= int_vec_d;
      int_pri_q  <= int_pri_d;
      int_src_q  <= int_src_d;
      pri_q      <= pri_d;
      vec_q      <= vec_d;
    end
  end

  assign bus.int_req = (state_q == S_REQ);
  assign bus.int_vec = int_vec_q;
  assign bus.int_pri = int_pri_q;
  assign bus.int_src = int_src_q;
  assign pending     = pending_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_lc3_int_arbiter.sv
// Bench for lc3_int_arbiter: edge-mode instance driven from a cycle table plus
// hand sequences, and a level-mode instance for re-grant and mid-handshake reset.
module tb_lc3_int_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_irq;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic       cfg_en;
  logic [2:0] cfg_pri;
  logic [7:0] cfg_vec;
  logic [2:0] cur_pl;
  logic       int_ack;
  logic [3:0] pending_e, ovf_e, pending_l, ovf_l;

  always #5 clk = ~clk;

  lc3_int_arbiter_if #(.PRI_W(3), .VEC_W(8), .IDX_W(2)) bus_e ();
  lc3_int_arbiter_if #(.PRI_W(3), .VEC_W(8), .IDX_W(2)) bus_l ();

  assign bus_e.cur_pl  = cur_pl;
  assign bus_e.int_ack = int_ack;
  assign bus_l.cur_pl  = cur_pl;
  assign bus_l.int_ack = int_ack;

  lc3_int_arbiter #(.NUM_SRC(4), .PRI_W(3), .VEC_W(8), .EDGE_MODE(1)) dut_e (
    .clk(clk), .rst(rst), .src_irq(src_irq),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_pri(cfg_pri), .cfg_vec(cfg_vec),
    .pending(pending_e), .ovf(ovf_e), .bus(bus_e.master)
  );

  lc3_int_arbiter #(.NUM_SRC(4), .PRI_W(3), .VEC_W(8), .EDGE_MODE(0)) dut_l (
    .clk(clk), .rst(rst), .src_irq(src_irq),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_pri(cfg_pri), .cfg_vec(cfg_vec),
    .pending(pending_l), .ovf(ovf_l), .bus(bus_l.master)
  );

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [1:0] idx;
    logic       en;
    logic [2:0] pri;
    logic [7:0] vec;
    logic [2:0] pl;
    logic       ack;
    logic       e_req;
    logic [7:0] e_vec;
    logic [2:0] e_pri;
    logic [1:0] e_src;
    logic [3:0] e_pend;
    logic [3:0] e_ovf;
  } vec_t;

  localparam int NROWS = 36;
  vec_t tbl [NROWS];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(int irq, int we, int idx, int en, int pri, int vec, int pl, int ack,
                              int req, int evec, int epri, int esrc, int epend, int eovf);
    vec_t v;
    v.irq = 4'(irq);   v.we = 1'(we);       v.idx = 2'(idx);     v.en = 1'(en);
    v.pri = 3'(pri);   v.vec = 8'(vec);     v.pl = 3'(pl);       v.ack = 1'(ack);
    v.e_req = 1'(req); v.e_vec = 8'(evec);  v.e_pri = 3'(epri);  v.e_src = 2'(esrc);
    v.e_pend = 4'(epend); v.e_ovf = 4'(eovf);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_e(input string tag, input int req, input int vec, input int pri,
                       input int src, input int pend, input int ovfv);
    chk({tag, ".req"},  32'(bus_e.int_req), 32'(req));
    chk({tag, ".vec"},  32'(bus_e.int_vec), 32'(vec));
    chk({tag, ".pri"},  32'(bus_e.int_pri), 32'(pri));
    chk({tag, ".src"},  32'(bus_e.int_src), 32'(src));
    chk({tag, ".pend"}, 32'(pending_e),     32'(pend));
    chk({tag, ".ovf"},  32'(ovf_e),         32'(ovfv));
  endtask

  initial begin
    rst = 1'b1; src_irq = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_pri = '0; cfg_vec = '0; cur_pl = '0; int_ack = 1'b0;

    //            irq     we idx en pri vec  pl ack | req vec  pri src pend    ovf
    tbl[0]  = mk('b0000, 1, 1, 1, 4, 'h81, 0, 0,  0, 'h00, 0, 0, 'b0000, 'b0000);
    tbl[1]  = mk('b0000, 1, 0, 1, 2, 'h40, 0, 0,  0, 'h00, 0, 0, 'b0000, 'b0000);
    tbl[2]  = mk('b0000, 1, 2, 1, 6, 'hC2, 0, 0,  0, 'h00, 0, 0, 'b0000, 'b0000);
    tbl[3]  = mk('b0000, 1, 3, 1, 5, 'hD3, 0, 0,  0, 'h00, 0, 0, 'b0000, 'b0000);
    tbl[4]  = mk('b0010, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 0, 'b0010, 'b0000);
    tbl[5]  = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  1, 'h81, 4, 1, 'b0010, 'b0000);
    tbl[6]  = mk('b0000, 0, 0, 0, 0, 'h00, 0, 1,  0, 'h81, 4, 1, 'b0000, 'b0000);
    tbl[7]  = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 4, 1, 'b0000, 'b0000);
    tbl[8]  = mk('b0101, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 4, 1, 'b0101, 'b0000);
    tbl[9]  = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  1, 'hC2, 6, 2, 'b0101, 'b0000);
    tbl[10] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 1,  0, 'hC2, 6, 2, 'b0001, 'b0000);
    tbl[11] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'hC2, 6, 2, 'b0001, 'b0000);
    tbl[12] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  1, 'h40, 2, 0, 'b0001, 'b0000);
    tbl[13] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 1,  0, 'h40, 2, 0, 'b0000, 'b0000);
    tbl[14] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h40, 2, 0, 'b0000, 'b0000);
    tbl[15] = mk('b1010, 1, 1, 1, 5, 'h81, 0, 0,  0, 'h40, 2, 0, 'b1010, 'b0000);
    tbl[16] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  1, 'h81, 5, 1, 'b1010, 'b0000);
    tbl[17] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 1,  0, 'h81, 5, 1, 'b1000, 'b0000);
    tbl[18] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 5, 1, 'b1000, 'b0000);
    tbl[19] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  1, 'hD3, 5, 3, 'b1000, 'b0000);
    tbl[20] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 1,  0, 'hD3, 5, 3, 'b0000, 'b0000);
    tbl[21] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'hD3, 5, 3, 'b0000, 'b0000);
    tbl[22] = mk('b0010, 0, 0, 0, 0, 'h00, 0, 0,  0, 'hD3, 5, 3, 'b0010, 'b0000);
    tbl[23] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  1, 'h81, 5, 1, 'b0010, 'b0000);
    tbl[24] = mk('b0010, 0, 0, 0, 0, 'h00, 0, 0,  1, 'h81, 5, 1, 'b0010, 'b0010);
    tbl[25] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  1, 'h81, 5, 1, 'b0010, 'b0010);
    tbl[26] = mk('b0010, 0, 0, 0, 0, 'h00, 0, 1,  0, 'h81, 5, 1, 'b0010, 'b0010);
    tbl[27] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 5, 1, 'b0010, 'b0010);
    tbl[28] = mk('b0000, 1, 1, 1, 5, 'h81, 0, 0,  1, 'h81, 5, 1, 'b0010, 'b0000);
    tbl[29] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 1,  0, 'h81, 5, 1, 'b0000, 'b0000);
    tbl[30] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 5, 1, 'b0000, 'b0000);
    tbl[31] = mk('b0001, 1, 0, 0, 2, 'h40, 0, 0,  0, 'h81, 5, 1, 'b0001, 'b0000);
    tbl[32] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 5, 1, 'b0001, 'b0000);
    tbl[33] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 5, 1, 'b0001, 'b0000);
    tbl[34] = mk('b0000, 1, 0, 1, 0, 'h40, 0, 0,  0, 'h81, 5, 1, 'b0001, 'b0000);
    tbl[35] = mk('b0000, 0, 0, 0, 0, 'h00, 0, 0,  0, 'h81, 5, 1, 'b0001, 'b0000);

    step();
    step();
    chk_e("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.l_req", 32'(bus_l.int_req), 32'd0);
    rst = 1'b0;

    for (int r = 0; r < NROWS; r++) begin
      src_irq = tbl[r].irq; cfg_we = tbl[r].we; cfg_idx = tbl[r].idx; cfg_en = tbl[r].en;
      cfg_pri = tbl[r].pri; cfg_vec = tbl[r].vec; cur_pl = tbl[r].pl; int_ack = tbl[r].ack;
      step();
      chk_e($sformatf("row%0d", r), int'(tbl[r].e_req), int'(tbl[r].e_vec), int'(tbl[r].e_pri),
            int'(tbl[r].e_src), int'(tbl[r].e_pend), int'(tbl[r].e_ovf));
    end
    src_irq = '0; cfg_we = 1'b0; int_ack = 1'b0;

    // Priority threshold against cur_pl, then REQ frozen against cur_pl/cfg changes.
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b1; cfg_pri = 3'd4; cfg_vec = 8'hC2; cur_pl = 3'd4;
    step();
    cfg_we = 1'b0;
    chk("pl_eq.req", 32'(bus_e.int_req), 32'd0);
    src_irq = 4'b0100;
    step();
    src_irq = '0;
    chk("pl_eq.pend", 32'(pending_e), 32'h5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pl_eq.blocked%0d", i), 32'(bus_e.int_req), 32'd0);
    end
    cur_pl = 3'd3;
    step();
    chk("pl_low.req", 32'(bus_e.int_req), 32'd1);
    chk("pl_low.vec", 32'(bus_e.int_vec), 32'hC2);
    chk("pl_low.pri", 32'(bus_e.int_pri), 32'd4);
    chk("pl_low.src", 32'(bus_e.int_src), 32'd2);
    cur_pl = 3'd7; src_irq = 4'b1000;
    step();
    src_irq = '0;
    chk("pl_high.req", 32'(bus_e.int_req), 32'd1);
    chk("pl_high.vec", 32'(bus_e.int_vec), 32'hC2);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b1; cfg_pri = 3'd4; cfg_vec = 8'hEE;
    step();
    cfg_we = 1'b0;
    chk("cfg_in_req.vec", 32'(bus_e.int_vec), 32'hC2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("stall%0d.req", i), 32'(bus_e.int_req), 32'd1);
      chk($sformatf("stall%0d.vec", i), 32'(bus_e.int_vec), 32'hC2);
    end
    cur_pl = 3'd0; int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("ack.req", 32'(bus_e.int_req), 32'd0);
    chk("ack.pend", 32'(pending_e), 32'h9);
    step();
    chk("hold_gap.req", 32'(bus_e.int_req), 32'd0);
    step();
    chk("next.req", 32'(bus_e.int_req), 32'd1);
    chk("next.vec", 32'(bus_e.int_vec), 32'hD3);
    chk("next.pri", 32'(bus_e.int_pri), 32'd5);
    chk("next.src", 32'(bus_e.int_src), 32'd3);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    step();

    // Level-mode instance: re-grant while level stays high, then reset inside REQ.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("lvl.rst_req", 32'(bus_l.int_req), 32'd0);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b1; cfg_pri = 3'd4; cfg_vec = 8'h81; cur_pl = 3'd0;
    step();
    cfg_we = 1'b0;
    src_irq = 4'b0010;
    step();
    chk("lvl.pend", 32'(pending_l), 32'h2);
    chk("lvl.req0", 32'(bus_l.int_req), 32'd0);
    step();
    chk("lvl.req1", 32'(bus_l.int_req), 32'd1);
    chk("lvl.vec", 32'(bus_l.int_vec), 32'h81);
    chk("lvl.pri", 32'(bus_l.int_pri), 32'd4);
    chk("lvl.src", 32'(bus_l.int_src), 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("lvl.ack_req", 32'(bus_l.int_req), 32'd0);
    chk("lvl.ack_pend", 32'(pending_l), 32'h2);
    step();
    chk("lvl.hold_req", 32'(bus_l.int_req), 32'd0);
    step();
    chk("lvl.regrant", 32'(bus_l.int_req), 32'd1);
    rst = 1'b1;
    step();
    chk("lvl.midrst_req", 32'(bus_l.int_req), 32'd0);
    chk("lvl.midrst_pend", 32'(pending_l), 32'h0);
    chk("lvl.ovf", 32'(ovf_l), 32'h0);
    rst = 1'b0;
    step();
    chk("lvl.post_pend", 32'(pending_l), 32'h2);
    step();
    chk("lvl.en_cleared", 32'(bus_l.int_req), 32'd0);
    src_irq = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
